// File: rtl/spi_master_if.sv
// Host-side handshake bundle for spi_master.
// The "master" modport is the host view. The "slave" modport is the spi_master view.
interface spi_master_if;
    logic       start;
    logic [9:0] tx_word;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output start,
        output tx_word,
        input  busy,
        input  done,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  start,
        input  tx_word,
        output busy,
        output done,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/spi_master.sv
// SPI initiator: sends a command bit plus a 10-bit frame MSB-first on MOSI.
// Read-data frames (opcode 2'b11) keep SS_n low, wait RD_LAT edges and then
// capture an 8-bit MISO reply. All outputs are registered.
module spi_master #(
    parameter int unsigned RD_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  host,
    output logic         SS_n,
    output logic         MOSI,
    input  logic         MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CMD,
        SHIFT,
        WAIT,
        CAPTURE,
        FINISH
    } state_t;

    // WAIT spends RD_LAT-1 edges, so it exits when the counter reaches RD_LAT-2.
    localparam logic [3:0] WAIT_LAST = 4'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    state_t     state;
    logic [9:0] shift_reg;
    logic [7:0] cap_reg;
    logic [3:0] cnt;
    logic       is_rd;

    // Frame sequencer. It shares one counter for the shift, wait and capture phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shift_reg     <= '0;
            cap_reg       <= '0;
            cnt           <= '0;
            is_rd         <= 1'b0;
            SS_n          <= 1'b1;
            MOSI          <= 1'b0;
            host.busy     <= 1'b0;
            host.done     <= 1'b0;
            host.rd_valid <= 1'b0;
            host.rd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    host.done     <= 1'b0;
                    host.rd_valid <= 1'b0;
                    if (host.start) begin
                        shift_reg <= host.tx_word;
                        is_rd     <= (host.tx_word[9:8] == 2'b11);
                        cnt       <= '0;
                        SS_n      <= 1'b0;
                        host.busy <= 1'b1;
                        MOSI      <= host.tx_word[9];
                        state     <= SEL;
                    end
                end

                SEL: begin
                    // Slave leaves idle during this cycle; the command bit stays on MOSI.
                    state <= CMD;
                end

                CMD: begin
                    MOSI  <= shift_reg[9];
                    cnt   <= '0;
                    state <= SHIFT;
                end

                SHIFT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        // The tenth SHIFT edge is the slave's last MOSI sample.
                        MOSI <= 1'b0;
                        if (is_rd) begin
                            cnt   <= '0;
                            state <= (RD_LAT == 1) ? CAPTURE : WAIT;
                        end else begin
                            SS_n      <= 1'b1;
                            host.done <= 1'b1;
                            host.busy <= 1'b0;
                            state     <= FINISH;
                        end
                    end else begin
                        MOSI      <= shift_reg[8];
                        shift_reg <= {shift_reg[8:0], 1'b0};
                    end
                end

                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                CAPTURE: begin
                    cap_reg <= {cap_reg[6:0], MISO};
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        host.rd_data  <= {cap_reg[6:0], MISO};
                        host.rd_valid <= 1'b1;
                        host.done     <= 1'b1;
                        host.busy     <= 1'b0;
                        SS_n          <= 1'b1;
                        state         <= FINISH;
                    end
                end

                FINISH: begin
                    host.done     <= 1'b0;
                    host.rd_valid <= 1'b0;
                    cnt           <= '0;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
